// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store definitions: RV32I funct3 codes, exception causes and LSU FSM states.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] CAUSE_NONE        = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_EXC    = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational funct3 legality and natural-alignment check for one load/store request.
module lsu_align_chk
  import lsu_ctrl_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr,
  output logic       legal,
  output logic       misaligned,
  output logic [3:0] cause
);

  always_comb begin
    legal = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: legal = 1'b1;
        default:             legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
        default:                            legal = 1'b0;
      endcase
    end

    // funct3[1:0] encodes the access size for every legal code
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr;
      default: misaligned = 1'b0;
    endcase

    if (!legal)          cause = CAUSE_ILLEGAL;
    else if (misaligned) cause = we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    else                 cause = CAUSE_NONE;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: accepts one request, drives data_mem for one cycle, then returns
// a load/store response or a one-cycle exception; keeps wrapping debug counters.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  input  logic                  flush,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_is_load,
  output logic [4:0]            rsp_rd,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  exc_valid,
  output logic [3:0]            exc_cause,
  output logic [ADDR_WIDTH-1:0] exc_addr,
  output logic [CNT_WIDTH-1:0]  ld_cnt,
  output logic [CNT_WIDTH-1:0]  st_cnt,
  output logic [CNT_WIDTH-1:0]  exc_cnt
);

  lsu_state_e            state_q;
  logic                  req_we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [4:0]            rd_q;
  logic                  rsp_is_load_q;
  logic [4:0]            rsp_rd_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [3:0]            exc_cause_q;
  logic [ADDR_WIDTH-1:0] exc_addr_q;
  logic [CNT_WIDTH-1:0]  ld_cnt_q, st_cnt_q, exc_cnt_q;

  logic       chk_legal, chk_misaligned;
  logic [3:0] chk_cause;
  logic       accept, req_ok;

  lsu_align_chk u_align_chk (
    .we         (req_we),
    .funct3     (req_funct3),
    .addr       (req_addr[1:0]),
    .legal      (chk_legal),
    .misaligned (chk_misaligned),
    .cause      (chk_cause)
  );

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready && !flush;
  assign req_ok    = chk_legal && !chk_misaligned;

  // Reset gates the write strobe combinationally so a store caught mid-ACCESS is dropped
  assign mem_wr_en  = (state_q == ST_ACCESS) && req_we_q && !reset;
  assign mem_funct3 = (state_q == ST_ACCESS) ? funct3_q : F3_LW;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_is_load = rsp_is_load_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign exc_valid   = (state_q == ST_EXC);
  assign exc_cause   = exc_cause_q;
  assign exc_addr    = exc_addr_q;
  assign ld_cnt      = ld_cnt_q;
  assign st_cnt      = st_cnt_q;
  assign exc_cnt     = exc_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_we_q      <= 1'b0;
      funct3_q      <= F3_LW;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      rsp_is_load_q <= 1'b0;
      rsp_rd_q      <= '0;
      rsp_rdata_q   <= '0;
      exc_cause_q   <= '0;
      exc_addr_q    <= '0;
      ld_cnt_q      <= '0;
      st_cnt_q      <= '0;
      exc_cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (req_ok) begin
              req_we_q <= req_we;
              funct3_q <= req_funct3;
              addr_q   <= req_addr;
              wdata_q  <= req_wdata;
              rd_q     <= req_rd;
              state_q  <= ST_ACCESS;
            end else begin
              exc_cause_q <= chk_cause;
              exc_addr_q  <= req_addr;
              state_q     <= ST_EXC;
            end
          end
        end
        ST_ACCESS: begin
          rsp_is_load_q <= !req_we_q;
          rsp_rd_q      <= rd_q;
          rsp_rdata_q   <= req_we_q ? '0 : mem_rdata;
          state_q       <= flush ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          // A handshake wins over a simultaneous flush: the response counts as delivered
          if (rsp_ready) begin
            if (rsp_is_load_q) ld_cnt_q <= ld_cnt_q + CNT_WIDTH'(1);
            else               st_cnt_q <= st_cnt_q + CNT_WIDTH'(1);
            state_q <= ST_IDLE;
          end else if (flush) begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXC: begin
          exc_cnt_q <= exc_cnt_q + CNT_WIDTH'(1);
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small byte-addressed data_mem model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_we, flush, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [4:0]  req_rd;
  logic        req_ready, mem_wr_en, rsp_valid, rsp_is_load, exc_valid;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, rsp_rdata, exc_addr;
  logic [4:0]  rsp_rd;
  logic [3:0]  exc_cause;
  logic [15:0] ld_cnt, st_cnt, exc_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:255];
  logic [7:0] ma;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .flush(flush), .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_load(rsp_is_load),
    .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_addr(exc_addr), .ld_cnt(ld_cnt), .st_cnt(st_cnt), .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  // data_mem model: combinational, already-extended read; synchronous write
  always_comb begin
    ma = mem_addr[7:0];
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
      3'b001:  mem_rdata = {{16{mem[ma+8'd1][7]}}, mem[ma+8'd1], mem[ma]};
      3'b100:  mem_rdata = {24'd0, mem[ma]};
      3'b101:  mem_rdata = {16'd0, mem[ma+8'd1], mem[ma]};
      default: mem_rdata = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      case (mem_funct3)
        3'b000: mem[mem_addr[7:0]] <= mem_wdata[7:0];
        3'b001: begin
          mem[mem_addr[7:0]]       <= mem_wdata[7:0];
          mem[mem_addr[7:0]+8'd1]  <= mem_wdata[15:8];
        end
        default: begin
          mem[mem_addr[7:0]]       <= mem_wdata[7:0];
          mem[mem_addr[7:0]+8'd1]  <= mem_wdata[15:8];
          mem[mem_addr[7:0]+8'd2]  <= mem_wdata[23:16];
          mem[mem_addr[7:0]+8'd3]  <= mem_wdata[31:24];
        end
      endcase
    end
  end

  // Present a request in IDLE; returns #1 after the accepting edge
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Full load with rsp_ready high; returns sampled response, ends back in IDLE
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                         output logic vld, output logic [31:0] data);
    issue(1'b0, f3, a, 32'd0, 5'd1);
    @(posedge clk); #1;
    vld = rsp_valid; data = rsp_rdata;
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    issue(1'b1, f3, a, wd, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0;
    req_wdata = '0; req_rd = '0; flush = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    checks++; if ({rsp_valid, exc_valid, mem_wr_en} !== 3'b000) begin errors++; $display("FAIL rst_valids got %b exp 000", {rsp_valid, exc_valid, mem_wr_en}); end
    checks++; if (mem_funct3 !== 3'b010) begin errors++; $display("FAIL rst_mem_funct3 got %b exp 010", mem_funct3); end
    checks++; if ({mem_addr, mem_wdata, rsp_rdata} !== 96'd0) begin errors++; $display("FAIL rst_data got %h %h %h exp 0", mem_addr, mem_wdata, rsp_rdata); end
    checks++; if ({ld_cnt, st_cnt, exc_cnt} !== 48'd0) begin errors++; $display("FAIL rst_cnt got %0d %0d %0d exp 0", ld_cnt, st_cnt, exc_cnt); end
    reset = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_store_load();
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL sw_wr_en_access got %b exp 1", mem_wr_en); end
    checks++; if ({mem_addr, mem_wdata} !== {32'h10, 32'hDEADBEEF}) begin errors++; $display("FAIL sw_bus got %h %h exp 10 deadbeef", mem_addr, mem_wdata); end
    checks++; if ({mem_funct3, req_ready, rsp_valid} !== 5'b010_0_0) begin errors++; $display("FAIL sw_access_ctl got %b exp 01000", {mem_funct3, req_ready, rsp_valid}); end
    @(posedge clk); #1;
    checks++; if ({mem_wr_en, rsp_valid, rsp_is_load} !== 3'b010) begin errors++; $display("FAIL sw_resp got %b exp 010", {mem_wr_en, rsp_valid, rsp_is_load}); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL sw_rdata got %h exp 0", rsp_rdata); end
    @(posedge clk); #1;
    checks++; if (st_cnt !== 16'd1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_st_cnt got %0d/%b exp 1/0", st_cnt, rsp_valid); end
    issue(1'b0, 3'b010, 32'h10, 32'd0, 5'd5);
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL lw_wr_en got %b exp 0", mem_wr_en); end
    @(posedge clk); #1;
    checks++; if ({rsp_valid, rsp_is_load, rsp_rd} !== {2'b11, 5'd5}) begin errors++; $display("FAIL lw_resp got %b %b %0d exp 1 1 5", rsp_valid, rsp_is_load, rsp_rd); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", rsp_rdata); end
    @(posedge clk); #1;
    checks++; if (ld_cnt !== 16'd1) begin errors++; $display("FAIL lw_ld_cnt got %0d exp 1", ld_cnt); end
  endtask

  task automatic test_byte_half();
    logic v; logic [31:0] d;
    do_store(3'b000, 32'h13, 32'h00000080);
    do_load(3'b000, 32'h13, v, d);
    checks++; if (v !== 1'b1 || d !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %b %h exp 1 ffffff80", v, d); end
    do_load(3'b100, 32'h13, v, d);
    checks++; if (v !== 1'b1 || d !== 32'h00000080) begin errors++; $display("FAIL lbu got %b %h exp 1 00000080", v, d); end
    do_load(3'b010, 32'h10, v, d);
    checks++; if (d !== 32'h80ADBEEF) begin errors++; $display("FAIL sb_other_bytes got %h exp 80adbeef", d); end
    do_load(3'b001, 32'h12, v, d);
    checks++; if (d !== 32'hFFFF80AD) begin errors++; $display("FAIL lh got %h exp ffff80ad", d); end
    do_load(3'b101, 32'h12, v, d);
    checks++; if (d !== 32'h000080AD) begin errors++; $display("FAIL lhu got %h exp 000080ad", d); end
    checks++; if (ld_cnt !== 16'd6 || st_cnt !== 16'd2) begin errors++; $display("FAIL byte_cnts got %0d %0d exp 6 2", ld_cnt, st_cnt); end
  endtask

  task automatic test_exceptions();
    logic v; logic [31:0] d;
    issue(1'b0, 3'b010, 32'h12, 32'd0, 5'd3);
    checks++; if ({exc_valid, exc_cause} !== {1'b1, 4'd4} || exc_addr !== 32'h12) begin errors++; $display("FAIL lw_misalign got %b %0d %h exp 1 4 12", exc_valid, exc_cause, exc_addr); end
    checks++; if ({rsp_valid, mem_wr_en} !== 2'b00) begin errors++; $display("FAIL lw_misalign_side got %b exp 00", {rsp_valid, mem_wr_en}); end
    @(posedge clk); #1;
    checks++; if ({exc_valid, rsp_valid, req_ready} !== 3'b001) begin errors++; $display("FAIL exc_one_cycle got %b exp 001", {exc_valid, rsp_valid, req_ready}); end
    issue(1'b1, 3'b001, 32'h11, 32'h0000AAAA, 5'd0);
    checks++; if ({exc_valid, exc_cause, mem_wr_en} !== {1'b1, 4'd6, 1'b0} || exc_addr !== 32'h11) begin errors++; $display("FAIL sh_misalign got %b %0d %b %h exp 1 6 0 11", exc_valid, exc_cause, mem_wr_en, exc_addr); end
    @(posedge clk); #1;
    issue(1'b0, 3'b011, 32'h10, 32'd0, 5'd3);
    checks++; if ({exc_valid, exc_cause} !== {1'b1, 4'd2}) begin errors++; $display("FAIL ld_illegal got %b %0d exp 1 2", exc_valid, exc_cause); end
    @(posedge clk); #1;
    checks++; if (exc_cnt !== 16'd3) begin errors++; $display("FAIL exc_cnt3 got %0d exp 3", exc_cnt); end
    issue(1'b0, 3'b011, 32'h11, 32'd0, 5'd3);
    checks++; if (exc_cause !== 4'd2) begin errors++; $display("FAIL illegal_priority got %0d exp 2", exc_cause); end
    @(posedge clk); #1;
    issue(1'b1, 3'b100, 32'h12, 32'd0, 5'd0);
    checks++; if ({exc_valid, exc_cause} !== {1'b1, 4'd2}) begin errors++; $display("FAIL st_illegal got %b %0d exp 1 2", exc_valid, exc_cause); end
    @(posedge clk); #1;
    checks++; if (exc_cnt !== 16'd5) begin errors++; $display("FAIL exc_cnt5 got %0d exp 5", exc_cnt); end
    do_load(3'b010, 32'h10, v, d);
    checks++; if (d !== 32'h80ADBEEF) begin errors++; $display("FAIL sh_mem_unchanged got %h exp 80adbeef", d); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h10, 32'd0, 5'd9);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, req_ready} !== 2'b10 || rsp_rdata !== 32'h80ADBEEF || rsp_rd !== 5'd9) begin errors++; $display("FAIL bp_hold[%0d] got %b %h %0d exp 10 80adbeef 9", i, {rsp_valid, req_ready}, rsp_rdata, rsp_rd); end
      @(posedge clk); #1;
    end
    checks++; if (ld_cnt !== 16'd7) begin errors++; $display("FAIL bp_cnt_before got %0d exp 7", ld_cnt); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({rsp_valid, req_ready} !== 2'b01 || ld_cnt !== 16'd8) begin errors++; $display("FAIL bp_release got %b %0d exp 01 8", {rsp_valid, req_ready}, ld_cnt); end
  endtask

  task automatic test_flush();
    logic v; logic [31:0] d;
    rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h10, 32'd0, 5'd2);
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL fl_resp got %b exp 1", rsp_valid); end
    flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || ld_cnt !== 16'd8) begin errors++; $display("FAIL fl_drop got %b %0d exp 0 8", rsp_valid, ld_cnt); end
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h55555555; req_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if ({req_ready, mem_wr_en} !== 2'b10) begin errors++; $display("FAIL fl_block_accept got %b exp 10", {req_ready, mem_wr_en}); end
    req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    issue(1'b1, 3'b010, 32'h20, 32'h12345678, 5'd0);
    flush = 1'b1; #1;
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL fl_access_wr got %b exp 1", mem_wr_en); end
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if ({rsp_valid, req_ready} !== 2'b01 || st_cnt !== 16'd2) begin errors++; $display("FAIL fl_no_ack got %b %0d exp 01 2", {rsp_valid, req_ready}, st_cnt); end
    do_load(3'b010, 32'h20, v, d);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL fl_store_written got %h exp 12345678", d); end
    do_load(3'b010, 32'h30, v, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fl_blocked_store got %h exp 0", d); end
  endtask

  task automatic test_reset_mid();
    logic v; logic [31:0] d;
    rsp_ready = 1'b1;
    issue(1'b1, 3'b010, 32'h24, 32'hCAFEF00D, 5'd0);
    reset = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1; #1;
    checks++; if ({mem_wr_en, req_ready} !== 2'b00) begin errors++; $display("FAIL rm_gate got %b exp 00", {mem_wr_en, req_ready}); end
    @(posedge clk); #1;
    checks++; if ({rsp_valid, exc_valid, mem_wr_en, req_ready} !== 4'b0000) begin errors++; $display("FAIL rm_ctl got %b exp 0000", {rsp_valid, exc_valid, mem_wr_en, req_ready}); end
    checks++; if ({mem_addr, mem_wdata, rsp_rdata, exc_addr} !== 128'd0 || mem_funct3 !== 3'b010) begin errors++; $display("FAIL rm_data got %h %h %h %h %b exp 0 0 0 0 010", mem_addr, mem_wdata, rsp_rdata, exc_addr, mem_funct3); end
    checks++; if ({ld_cnt, st_cnt, exc_cnt} !== 48'd0) begin errors++; $display("FAIL rm_cnt got %0d %0d %0d exp 0", ld_cnt, st_cnt, exc_cnt); end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_idle got %b exp 1", req_ready); end
    do_load(3'b010, 32'h24, v, d);
    checks++; if (v !== 1'b1 || d !== 32'h0 || ld_cnt !== 16'd1) begin errors++; $display("FAIL rm_no_write got %b %h %0d exp 1 0 1", v, d, ld_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_store_load();
    test_byte_half();
    test_exceptions();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
